clk_step_gen: RTL
=================

Name: clk_step_gen

Overview:
Parametrised successor to the fixed-ratio clock divider bank in the CPU top level. It generates NCH divided square-wave clocks from the board clock, each with its own runtime-programmable half-period. Run/stop/single-step mode is built in, and the raw step key is debounced on-chip. It feeds the cpu, ram and light_show clock inputs and gives the CPU_Controller states a real hardware step facility.

Parameters:
NCH, 5, number of divided-clock channels
CW, 32, width of each channel's half-period symbol and counter
DBW, 20, debounce counter width; the key must be stable for 2**DBW - 1 clk cycles

Ports:
clk  input  1  board clock
rst  input  1  asynchronous, active-high reset
div_sym  input  NCH*CW  per-channel half-period in clk cycles; channel i uses bits [i*CW +: CW]; a value of 0 is treated as 1
mode  input  2  00 stop, 01 single-step, 10 run, 11 run
ch_en  input  NCH  per-channel enable; a disabled channel holds div_clk low and its counter at 0
step_key  input  1  raw, undebounced step push-button, active-high
div_clk  output  NCH  divided square-wave clocks
tick  output  NCH  one-clk pulse in the cycle div_clk[i] rises
step_busy  output  1  high while a single-step period is in progress
key_db  output  1  debounced step key level

Behaviour:
- Reset: all counters = 0, div_clk = 0, tick = 0, step_busy = 0, key_db = 0, debounce counter = 0. Reset is asynchronous and active-high.
- Channel counter, per enabled channel that is advancing:
  - cnt increments each clk.
  - When cnt == sym-1 (sym = max(div_sym_i, 1)), cnt wraps to 0 and div_clk toggles.
  - Output period = 2*sym clk cycles, 50% duty.
  - div_clk, tick and cnt are all registered outputs.
- tick[i] = 1 in exactly the cycle where div_clk[i] goes 0 -> 1; otherwise 0.
- div_sym change: takes effect immediately on compare. If cnt >= new sym-1, the channel wraps on the next cycle; no counter overrun past 2**CW-1.
- Channel enable:
  - ch_en[i] = 0 forces cnt = 0 and div_clk = 0 synchronously.
  - Re-enabling starts from cnt = 0 with div_clk low.
- Mode FSM, states STOP, STEP_IDLE, STEP_RUN, RUN:
  - mode 00 -> STOP: counters and div_clk frozen at their current values.
  - mode 1x -> RUN: all enabled channels advance.
  - Entering mode 01 from any other mode -> STEP_IDLE. On the entry cycle all counters and div_clk clear to 0, so channels are phase-aligned.
  - STEP_IDLE: channels frozen low. An accepted key press moves to STEP_RUN with step_busy = 1.
  - STEP_RUN: each enabled channel advances until it completes exactly one full period (rise, then fall back to 0), then freezes. When every enabled channel has completed, the FSM returns to STEP_IDLE and step_busy drops in the same cycle as the last falling edge.
  - If no channel is enabled, a step press goes to STEP_RUN and returns to STEP_IDLE on the next cycle.
  - Key presses during STEP_RUN are ignored, not queued.
  - Mode change during STEP_RUN: abort immediately and go to the new mode's state; step_busy = 0.
  - RUN -> STOP -> RUN resumes from the frozen cnt/div_clk values with no glitch.
- Debounce:
  - step_key is synchronised through 2 flops.
  - Any change of the synchronised value from key_db reloads the debounce counter to 0.
  - key_db takes the new value when the counter reaches 2**DBW - 1.
  - An accepted press is the key_db 0 -> 1 transition; it is a single-cycle internal pulse.
- Simultaneous events:
  - A press in the same cycle as a mode change is dropped.
  - The wrap and the freeze for step completion evaluate in the same cycle, so a channel never emits a second rising edge in one step.
- Async reset mid-step: everything returns to reset values. After release, if mode = 01, the FSM is in STEP_IDLE.

Test Plan:
- Run, NCH=2, sym = {3, 1}, ch_en = 11 -> div_clk[0] period 6 clk, div_clk[1] period 2 clk; tick[0] every 6th cycle, one cycle wide.
- Run with sym0 = 4; at cnt = 3 write sym0 = 2 -> wrap next cycle, then period 4 clk; stop mid-high for 10 cycles -> div_clk held high, resumes with the remaining half-period.
- Step mode, DBW=3, sym = {2, 5} -> after one clean press: one rising edge per channel, step_busy high for 10 cycles (the longer period), then both low and frozen.
- Key bounce 1-0-1 at 2-cycle spacing, then held 20 cycles -> exactly one accepted press; a second press during step_busy -> no extra edge.
- Mode 01 -> 10 during STEP_RUN -> step_busy = 0 next cycle, channels free-run; assert rst mid-period -> div_clk = 0, tick = 0, cnt = 0 immediately, without waiting for a clk edge.
- ch_en[1] = 0 in run -> div_clk[1] = 0, tick[1] never pulses; sym = 0 -> behaves as sym = 1 (period 2).

Source files
------------

// File: rtl/clk_step_gen.sv
// clk_step_gen: bank of programmable divided clocks with run/stop/single-step control and on-chip key debounce
module clk_step_gen #(
  parameter int NCH = 5,
  parameter int CW  = 32,
  parameter int DBW = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*CW-1:0] div_sym,
  input  logic [1:0]        mode,
  input  logic [NCH-1:0]    ch_en,
  input  logic              step_key,
  output logic [NCH-1:0]    div_clk,
  output logic [NCH-1:0]    tick,
  output logic              step_busy,
  output logic              key_db
);
  typedef enum logic [1:0] {STOP, STEP_IDLE, STEP_RUN, RUN} state_t;
  // counter value on whose edge the key has differed for 2**DBW-1 cycles
  localparam logic [DBW-1:0] DB_LAST = {{(DBW-1){1'b1}}, 1'b0};
  state_t state, state_nx;
  logic [1:0] sync;
  logic [DBW-1:0] dbc;
  logic press, entry, step_run, all_done;
  logic [CW-1:0] cnt [NCH];
  logic [CW-1:0] lim [NCH];
  logic [NCH-1:0] wrap, adv, fall, done;
  assign press = sync[1] & ~key_db & (dbc == DB_LAST);
  assign entry = (mode == 2'b01) && (state == STOP || state == RUN);
  assign step_run = (mode == 2'b01) && (state == STEP_RUN);
  assign all_done = &(done | fall | ~ch_en);
  assign step_busy = state == STEP_RUN;
  // >= compare lets a shrunken half-period wrap at once instead of overrunning
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lim[i] = (div_sym[i*CW +: CW] == '0) ? '0 : div_sym[i*CW +: CW] - 1'b1;
      wrap[i] = cnt[i] >= lim[i];
      adv[i] = ch_en[i] & (mode[1] | (step_run & ~done[i]));
      fall[i] = adv[i] & wrap[i] & div_clk[i];
    end
  end
  always_comb
    state_nx = mode[1] ? RUN :
               (mode == 2'b00) ? STOP :
               (state == STOP || state == RUN) ? STEP_IDLE :
               (state == STEP_IDLE && press) ? STEP_RUN :
               (state == STEP_RUN && all_done) ? STEP_IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= STEP_IDLE;
      sync <= '0;
      dbc <= '0;
      key_db <= 1'b0;
      done <= '0;
      div_clk <= '0;
      tick <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      state <= state_nx;
      sync <= {sync[0], step_key};
      dbc <= (sync[1] == key_db || dbc == DB_LAST) ? '0 : dbc + 1'b1;
      if (dbc == DB_LAST && sync[1] != key_db) key_db <= sync[1];
      done <= step_run ? (done | fall) : '0;
      tick <= adv & wrap & ~div_clk;
      for (int i = 0; i < NCH; i++)
        if (!ch_en[i] || entry) begin
          cnt[i] <= '0;
          div_clk[i] <= 1'b0;
        end else if (adv[i]) begin
          cnt[i] <= wrap[i] ? '0 : cnt[i] + 1'b1;
          div_clk[i] <= div_clk[i] ^ wrap[i];
        end
    end
endmodule
